// File: rtl/rf_alu_datapath_p_if.sv
// Datapath-facing bus of rf_alu_datapath_p: RF access, ALU operand/op controls,
// registered result/flags and the multiplier busy/done handshake.
interface rf_alu_datapath_p_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              rf_write_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] rm_rd_addr;
  logic [ADDR_W-1:0] rn_addr;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] pc_in;
  logic [15:0]       instr;
  logic [DATA_W-1:0] rd_in;
  logic [1:0]        imm_sel;
  logic              alu_a_sel;
  logic [1:0]        alu_b_sel;
  logic [2:0]        alu_op;
  logic              alu_out_ce;
  logic [DATA_W-1:0] alu_out;
  logic [3:0]        nzvc;
  logic [DATA_W-1:0] imm_out;
  logic [DATA_W-1:0] read_a_data;
  logic              busy;
  logic              done;

  modport master (
    output rf_write_en, rd_addr, rm_rd_addr, rn_addr, write_data, pc_in, instr,
           rd_in, imm_sel, alu_a_sel, alu_b_sel, alu_op, alu_out_ce,
    input  alu_out, nzvc, imm_out, read_a_data, busy, done
  );

  modport slave (
    input  rf_write_en, rd_addr, rm_rd_addr, rn_addr, write_data, pc_in, instr,
           rd_in, imm_sel, alu_a_sel, alu_b_sel, alu_op, alu_out_ce,
    output alu_out, nzvc, imm_out, read_a_data, busy, done
  );
endinterface

// File: rtl/rf_alu_datapath_p.sv
// Parametrised register file + ALU datapath with registered ALUOut/NZVC and an
// iterative shift-add multiplier (one bit per cycle, busy/done handshake).
module rf_alu_datapath_p #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  rf_alu_datapath_p_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int MSB   = DATA_W - 1;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
    OP_XOR = 3'd4, OP_LSL = 3'd5, OP_LSR = 3'd6, OP_MUL = 3'd7
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  logic [NUM_REGS-1:0][DATA_W-1:0] rf_q;
  logic [ADDR_W-1:0] ra, rb;
  logic [DATA_W-1:0] read_b, imm, op_a, op_b, alu_res;
  logic              flag_v, flag_c;
  logic [3:0]        alu_flags;
  logic [DATA_W:0]   add_w, sub_w, shl_w, shr_w;
  logic [4:0]        shamt;

  state_e              state_q, state_d;
  logic [2*DATA_W-1:0] mcand_q, acc_q, acc_next;
  logic [DATA_W-1:0]   mplier_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                start, last, single;
  logic                unused_bits;

  assign unused_bits = ^{bus.instr[15:8], bus.rd_in[DATA_W-1:8]};

  // register file: combinational reads, no write-to-read bypass
  assign ra = bus.rm_rd_addr;
  assign rb = bus.rn_addr;
  assign bus.read_a_data = rf_q[ra];
  assign read_b          = rf_q[rb];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               rf_q <= '0;
    else if (bus.rf_write_en) rf_q[bus.rd_addr] <= bus.write_data;
  end

  always_comb begin
    imm = '0;
    case (bus.imm_sel)
      2'b00:   imm = {{(DATA_W-5){bus.instr[4]}}, bus.instr[4:0]};
      2'b01:   imm = {{(DATA_W-8){bus.instr[7]}}, bus.instr[7:0]};
      2'b10:   imm = {{(DATA_W-8){1'b0}}, bus.instr[7:0]};
      default: imm = {{(DATA_W-8){bus.rd_in[7]}}, bus.rd_in[7:0]};
    endcase
  end
  assign bus.imm_out = imm;

  assign op_a = bus.alu_a_sel ? bus.read_a_data : bus.pc_in;

  always_comb begin
    op_b = '0;
    case (bus.alu_b_sel)
      2'b00:   op_b = read_b;
      2'b01:   op_b = imm;
      2'b10:   op_b = '0;
      default: op_b = DATA_W'(2);
    endcase
  end

  // One extra bit on each side catches carry/borrow and the last bit shifted out;
  // shifts wider than the datapath fall out naturally as zero.
  assign shamt = op_b[4:0];
  assign add_w = {1'b0, op_a} + {1'b0, op_b};
  assign sub_w = {1'b0, op_a} - {1'b0, op_b};
  assign shl_w = {1'b0, op_a} << shamt;
  assign shr_w = {op_a, 1'b0} >> shamt;

  always_comb begin
    alu_res = '0;
    flag_v  = 1'b0;
    flag_c  = 1'b0;
    case (bus.alu_op)
      OP_ADD: begin
        alu_res = add_w[MSB:0];
        flag_c  = add_w[DATA_W];
        flag_v  = (op_a[MSB] == op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
      end
      OP_SUB: begin
        alu_res = sub_w[MSB:0];
        flag_c  = sub_w[DATA_W];
        flag_v  = (op_a[MSB] != op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
      end
      OP_AND: alu_res = op_a & op_b;
      OP_OR:  alu_res = op_a | op_b;
      OP_XOR: alu_res = op_a ^ op_b;
      OP_LSL: begin
        alu_res = shl_w[MSB:0];
        flag_c  = shl_w[DATA_W];
      end
      OP_LSR: begin
        alu_res = shr_w[DATA_W:1];
        flag_c  = shr_w[0];
      end
      default: alu_res = '0;
    endcase
  end
  assign alu_flags = {alu_res[MSB], ~|alu_res, flag_v, flag_c};

  // multiplier control
  assign start    = bus.alu_out_ce && (bus.alu_op == OP_MUL) && (state_q != S_RUN);
  assign single   = bus.alu_out_ce && (bus.alu_op != OP_MUL) && (state_q != S_RUN);
  assign last     = (state_q == S_RUN) && (cnt_q == CNT_W'(1));
  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last)  state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (start) begin
      mcand_q  <= {{DATA_W{1'b0}}, op_a};
      mplier_q <= op_b;
      acc_q    <= '0;
      cnt_q    <= CNT_W'(DATA_W);
    end else if (state_q == S_RUN) begin
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      acc_q    <= acc_next;
      cnt_q    <= cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.alu_out <= '0;
      bus.nzvc    <= '0;
    end else if (last) begin
      bus.alu_out <= acc_next[MSB:0];
      bus.nzvc    <= {acc_next[MSB], ~|acc_next[MSB:0], |acc_next[2*DATA_W-1:DATA_W], 1'b0};
    end else if (single) begin
      bus.alu_out <= alu_res;
      bus.nzvc    <= alu_flags;
    end
  end

  assign bus.busy = (state_q == S_RUN);
  assign bus.done = (state_q == S_DONE);
endmodule

// File: tb/tb_rf_alu_datapath_p.sv
// Bench for rf_alu_datapath_p: 16-bit and 32-bit instances, directed literal cases
// plus random traffic compared every cycle against an arithmetic reference model.
module tb_rf_alu_datapath_p;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  rf_alu_datapath_p_if #(.DATA_W(16), .ADDR_W(3)) i16 ();
  rf_alu_datapath_p_if #(.DATA_W(32), .ADDR_W(4)) i32 ();

  rf_alu_datapath_p #(.DATA_W(16), .NUM_REGS(8), .ADDR_W(3)) u16 (
    .clk(clk), .rst_n(rst_n), .bus(i16.slave));
  rf_alu_datapath_p #(.DATA_W(32), .NUM_REGS(16), .ADDR_W(4)) u32 (
    .clk(clk), .rst_n(rst_n), .bus(i32.slave));

  typedef struct packed {
    logic        we;
    logic [3:0]  rd, ra, rb;
    logic [31:0] wd, pc;
    logic [15:0] instr;
    logic [31:0] rdin;
    logic [1:0]  isel;
    logic        asel;
    logic [1:0]  bsel;
    logic [2:0]  op;
    logic        ce;
  } stim_t;

  typedef struct packed {
    logic [63:0] r;
    logic [3:0]  f;
  } res_t;

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 0;

  // reference state, one slot per instance
  logic [63:0] m_rf [2][16];
  logic [63:0] m_out [2];
  logic [3:0]  m_nzvc [2];
  int          m_cnt [2];
  res_t        m_res [2];
  bit          m_done [2];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] mask_of(int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic longint sx(logic [63:0] v, int w);
    if (v[w-1]) return longint'(v) - (longint'(1) << w);
    return longint'(v);
  endfunction

  function automatic bit ovf(longint s, int w);
    return (s > ((longint'(1) << (w-1)) - 1)) || (s < -(longint'(1) << (w-1)));
  endfunction

  function automatic logic [63:0] fimm(int w, stim_t s);
    longint x;
    case (s.isel)
      2'd0: begin x = longint'(s.instr[4:0]); if (x >= 16) x -= 32; end
      2'd1: begin x = longint'(s.instr[7:0]); if (x >= 128) x -= 256; end
      2'd2: x = longint'(s.instr[7:0]);
      default: begin x = longint'(s.rdin[7:0]); if (x >= 128) x -= 256; end
    endcase
    return 64'(x) & mask_of(w);
  endfunction

  // Result/flags straight from the operation definitions.
  function automatic res_t f_alu(int w, logic [2:0] op, logic [63:0] a, logic [63:0] b);
    logic [63:0] m, r, p;
    bit v, c;
    int sh;
    res_t o;
    m = mask_of(w); r = 0; v = 0; c = 0;
    case (op)
      3'd0: begin p = a + b; r = p & m; c = p[w]; v = ovf(sx(a, w) + sx(b, w), w); end
      3'd1: begin r = (a - b) & m; c = (a < b); v = ovf(sx(a, w) - sx(b, w), w); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin
        r = a; sh = int'(b[4:0]);
        for (int i = 0; i < sh; i++) begin c = r[w-1]; r = (r << 1) & m; end
      end
      3'd6: begin
        r = a; sh = int'(b[4:0]);
        for (int i = 0; i < sh; i++) begin c = r[0]; r = r >> 1; end
      end
      default: begin p = a * b; r = p & m; v = ((p >> w) != 0); end
    endcase
    o.r = r;
    o.f = {r[w-1], (r == 0), v, c};
    return o;
  endfunction

  function automatic stim_t idle_s();
    stim_t s = '0;
    return s;
  endfunction

  function automatic stim_t wr_s(int k, logic [31:0] v);
    stim_t s = '0;
    s.we = 1'b1; s.rd = 4'(k); s.wd = v;
    return s;
  endfunction

  function automatic stim_t op_s(logic [2:0] op, int ra, int rb, logic asel, logic [1:0] bsel);
    stim_t s = '0;
    s.op = op; s.ra = 4'(ra); s.rb = 4'(rb); s.asel = asel; s.bsel = bsel; s.ce = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] pick(int d);
    case ($urandom_range(0, 4))
      0: return 32'hFFFF_FFFF;
      1: return (d != 0) ? 32'h8000_0000 : 32'h0000_8000;
      2: return (d != 0) ? 32'h7FFF_FFFF : 32'h0000_7FFF;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  function automatic stim_t rnd_s(int d);
    stim_t s;
    int amax;
    amax = (d != 0) ? 15 : 7;
    s.we = 1'($urandom_range(0, 1));
    s.rd = 4'($urandom_range(0, amax));
    s.ra = 4'($urandom_range(0, amax));
    s.rb = 4'($urandom_range(0, amax));
    s.wd = pick(d);
    s.pc = pick(d);
    s.instr = 16'($urandom);
    s.rdin = $urandom;
    s.isel = 2'($urandom_range(0, 3));
    s.asel = 1'($urandom_range(0, 1));
    s.bsel = 2'($urandom_range(0, 3));
    s.op = 3'($urandom_range(0, 7));
    if (s.op == 3'd7 && $urandom_range(0, 3) != 0) s.op = 3'($urandom_range(0, 6));
    s.ce = ($urandom_range(0, 3) != 0);
    return s;
  endfunction

  task automatic drive(int d, stim_t s);
    if (d == 0) begin
      i16.rf_write_en = s.we;   i16.rd_addr = s.rd[2:0];
      i16.rm_rd_addr = s.ra[2:0]; i16.rn_addr = s.rb[2:0];
      i16.write_data = s.wd[15:0]; i16.pc_in = s.pc[15:0];
      i16.instr = s.instr;      i16.rd_in = s.rdin[15:0];
      i16.imm_sel = s.isel;     i16.alu_a_sel = s.asel;
      i16.alu_b_sel = s.bsel;   i16.alu_op = s.op; i16.alu_out_ce = s.ce;
    end else begin
      i32.rf_write_en = s.we;   i32.rd_addr = s.rd;
      i32.rm_rd_addr = s.ra;    i32.rn_addr = s.rb;
      i32.write_data = s.wd;    i32.pc_in = s.pc;
      i32.instr = s.instr;      i32.rd_in = s.rdin;
      i32.imm_sel = s.isel;     i32.alu_a_sel = s.asel;
      i32.alu_b_sel = s.bsel;   i32.alu_op = s.op; i32.alu_out_ce = s.ce;
    end
  endtask

  function automatic stim_t cur(int d);
    stim_t s;
    if (d == 0) begin
      s.we = i16.rf_write_en; s.rd = {1'b0, i16.rd_addr};
      s.ra = {1'b0, i16.rm_rd_addr}; s.rb = {1'b0, i16.rn_addr};
      s.wd = {16'h0, i16.write_data}; s.pc = {16'h0, i16.pc_in};
      s.instr = i16.instr; s.rdin = {16'h0, i16.rd_in};
      s.isel = i16.imm_sel; s.asel = i16.alu_a_sel; s.bsel = i16.alu_b_sel;
      s.op = i16.alu_op; s.ce = i16.alu_out_ce;
    end else begin
      s.we = i32.rf_write_en; s.rd = i32.rd_addr; s.ra = i32.rm_rd_addr; s.rb = i32.rn_addr;
      s.wd = i32.write_data; s.pc = i32.pc_in; s.instr = i32.instr; s.rdin = i32.rd_in;
      s.isel = i32.imm_sel; s.asel = i32.alu_a_sel; s.bsel = i32.alu_b_sel;
      s.op = i32.alu_op; s.ce = i32.alu_out_ce;
    end
    return s;
  endfunction

  // apply one cycle of stimulus to instance d, the other instance idles
  task automatic apply(int d, stim_t s);
    @(negedge clk);
    #1;
    drive(d, s);
    drive(1 - d, idle_s());
  endtask

  task automatic mreset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 16; k++) m_rf[d][k] = 0;
      m_out[d] = 0; m_nzvc[d] = 0; m_cnt[d] = 0; m_res[d] = '0; m_done[d] = 0;
    end
  endtask

  // A multiply is "remaining cycles + precomputed product"; ops take effect at the edge.
  task automatic mstep(int d, int w, stim_t s);
    logic [63:0] a, b;
    res_t r;
    bit dn;
    dn = 0;
    a = s.asel ? m_rf[d][s.ra] : {32'h0, s.pc};
    case (s.bsel)
      2'd0: b = m_rf[d][s.rb];
      2'd1: b = fimm(w, s);
      2'd2: b = 0;
      default: b = 2;
    endcase
    if (m_cnt[d] > 0) begin
      m_cnt[d]--;
      if (m_cnt[d] == 0) begin m_out[d] = m_res[d].r; m_nzvc[d] = m_res[d].f; dn = 1; end
    end else if (s.ce) begin
      r = f_alu(w, s.op, a, b);
      if (s.op == 3'd7) begin m_cnt[d] = w; m_res[d] = r; end
      else begin m_out[d] = r.r; m_nzvc[d] = r.f; end
    end
    m_done[d] = dn;
    if (s.we) m_rf[d][s.rd] = {32'h0, s.wd};
  endtask

  initial begin
    mreset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) mreset();
      else begin
        mstep(0, 16, cur(0));
        mstep(1, 32, cur(1));
      end
    end
  end

  // every-cycle comparison of both instances against the model
  initial begin
    stim_t s;
    forever begin
      @(negedge clk);
      if (rst_n && chk_on) begin
        s = cur(0);
        chk("w16 alu_out", 64'(i16.alu_out), m_out[0]);
        chk("w16 nzvc", 64'(i16.nzvc), 64'(m_nzvc[0]));
        chk("w16 busy", 64'(i16.busy), 64'(m_cnt[0] != 0));
        chk("w16 done", 64'(i16.done), 64'(m_done[0]));
        chk("w16 read_a", 64'(i16.read_a_data), m_rf[0][s.ra]);
        chk("w16 imm_out", 64'(i16.imm_out), fimm(16, s));
        s = cur(1);
        chk("w32 alu_out", 64'(i32.alu_out), m_out[1]);
        chk("w32 nzvc", 64'(i32.nzvc), 64'(m_nzvc[1]));
        chk("w32 busy", 64'(i32.busy), 64'(m_cnt[1] != 0));
        chk("w32 done", 64'(i32.done), 64'(m_done[1]));
        chk("w32 read_a", 64'(i32.read_a_data), m_rf[1][s.ra]);
        chk("w32 imm_out", 64'(i32.imm_out), fimm(32, s));
      end
    end
  end

  task automatic ck16(string nm, logic [15:0] eo, logic [3:0] ef);
    chk({nm, " out"}, 64'(i16.alu_out), 64'(eo));
    chk({nm, " nzvc"}, 64'(i16.nzvc), 64'(ef));
  endtask

  task automatic run16(stim_t s);
    apply(0, s);
    apply(0, idle_s());
  endtask

  task automatic wait_done(int d, int maxc, string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < maxc; i++) begin
      apply(d, idle_s());
      if ((d == 0) ? i16.done : i32.done) begin ok = 1; break; end
    end
    chk({nm, " done seen"}, 64'(ok), 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    stim_t s;
    int nb, nd;
    drive(0, idle_s());
    drive(1, idle_s());
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst w16 alu_out", 64'(i16.alu_out), 64'd0);
    chk("rst w16 nzvc", 64'(i16.nzvc), 64'd0);
    chk("rst w16 busy", 64'(i16.busy), 64'd0);
    chk("rst w16 done", 64'(i16.done), 64'd0);
    chk("rst w32 alu_out", 64'(i32.alu_out), 64'd0);
    chk("rst w32 read_a", 64'(i32.read_a_data), 64'd0);
    #1 rst_n = 1'b1;
    chk_on = 1;

    for (int k = 0; k < 8; k++) apply(0, wr_s(k, 32'(k)));
    run16(op_s(3'd0, 3, 5, 1, 2'b00)); ck16("add r3+r5", 16'h0008, 4'b0000);
    run16(op_s(3'd1, 3, 5, 1, 2'b00)); ck16("sub r3-r5", 16'hFFFE, 4'b1001);
    run16(op_s(3'd1, 5, 3, 1, 2'b00)); ck16("sub r5-r3", 16'h0002, 4'b0000);
    s = op_s(3'd0, 0, 0, 0, 2'b01); s.pc = 32'h7FFF; s.instr = 16'h0001;
    run16(s); ck16("add 7fff+1", 16'h8000, 4'b1010);
    s = op_s(3'd0, 6, 0, 1, 2'b01); s.instr = 16'h0007; s.isel = 2'b00;
    run16(s); ck16("imm5 pos", 16'h000D, 4'b0000);
    s = op_s(3'd0, 5, 0, 1, 2'b01); s.instr = 16'h0018; s.isel = 2'b00;
    run16(s); ck16("imm5 neg", 16'hFFFD, 4'b1000);
    s = op_s(3'd0, 3, 0, 1, 2'b01); s.instr = 16'h0080; s.isel = 2'b01;
    run16(s); ck16("imm8 sext", 16'hFF83, 4'b1000);
    s = op_s(3'd0, 2, 0, 1, 2'b01); s.instr = 16'h00FF; s.isel = 2'b10;
    run16(s); ck16("imm8 zext", 16'h0101, 4'b0000);
    s = op_s(3'd0, 1, 0, 1, 2'b01); s.isel = 2'b11; s.rdin = 32'hABAB;
    apply(0, s);
    #1 chk("imm rd_in form", 64'(i16.imm_out), 64'h0000_FFAB);
    apply(0, idle_s()); ck16("imm rd_in add", 16'hFFAC, 4'b1000);
    s = op_s(3'd0, 0, 0, 0, 2'b11); s.pc = 32'h1000;
    run16(s); ck16("pc+2", 16'h1002, 4'b0000);
    s = op_s(3'd5, 1, 0, 1, 2'b01); s.instr = 16'h000F;
    run16(s); ck16("lsl by 15", 16'h8000, 4'b1000);
    s = op_s(3'd5, 1, 0, 1, 2'b01); s.instr = 16'h0010;
    run16(s); ck16("lsl by 16", 16'h0000, 4'b0101);
    run16(op_s(3'd6, 3, 1, 1, 2'b00)); ck16("lsr by 1", 16'h0001, 4'b0001);
    run16(op_s(3'd4, 5, 3, 1, 2'b00)); ck16("xor", 16'h0006, 4'b0000);

    // MUL R7*R6 with an RF write to R7 and an ignored ce pulse while running
    apply(0, op_s(3'd7, 7, 6, 1, 2'b00));
    nb = 0; nd = 0;
    for (int i = 0; i < 40; i++) begin
      s = idle_s();
      if (i == 3) s = wr_s(7, 32'h0099);
      if (i == 6) s = op_s(3'd0, 3, 5, 1, 2'b00);
      apply(0, s);
      if (i16.busy) nb++;
      if (i16.done) nd++;
    end
    chk("mul busy cycles", 64'(nb), 64'd16);
    chk("mul done pulses", 64'(nd), 64'd1);
    ck16("mul 7*6", 16'h002A, 4'b0000);
    apply(0, wr_s(7, 32'h7));

    apply(0, wr_s(1, 32'h0100));
    apply(0, wr_s(2, 32'h0100));
    apply(0, op_s(3'd7, 1, 2, 1, 2'b00));
    wait_done(0, 40, "mul ovf");
    ck16("mul 100*100", 16'h0000, 4'b0110);

    // reset in the middle of a multiply
    apply(0, wr_s(1, 32'h3));
    run16(op_s(3'd0, 1, 2, 1, 2'b00));
    apply(0, op_s(3'd7, 1, 2, 1, 2'b00));
    s = idle_s(); s.ra = 4'd1;
    repeat (5) apply(0, s);
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", 64'(i16.busy), 64'd0);
    chk("abort done", 64'(i16.done), 64'd0);
    chk("abort alu_out", 64'(i16.alu_out), 64'd0);
    chk("abort read_a", 64'(i16.read_a_data), 64'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 30; i++) begin
      apply(0, idle_s());
      if (i16.done) nd++;
    end
    chk("abort no done", 64'(nd), 64'd0);

    for (int i = 0; i < 400; i++) apply(0, rnd_s(0));
    repeat (20) apply(0, idle_s());

    // 32-bit / 16-register instance
    apply(1, wr_s(1, 32'hFFFF_FFFF));
    apply(1, wr_s(2, 32'h1));
    apply(1, wr_s(15, 32'h1234_5678));
    apply(1, wr_s(3, 32'h0001_0000));
    apply(1, op_s(3'd0, 1, 2, 1, 2'b00));
    s = idle_s(); s.ra = 4'd15;
    apply(1, s);
    #1;
    chk("w32 add wrap out", 64'(i32.alu_out), 64'd0);
    chk("w32 add wrap nzvc", 64'(i32.nzvc), 64'b0101);
    chk("w32 r15 read", 64'(i32.read_a_data), 64'h1234_5678);
    apply(1, op_s(3'd7, 3, 3, 1, 2'b00));
    wait_done(1, 60, "w32 mul");
    chk("w32 mul out", 64'(i32.alu_out), 64'd0);
    chk("w32 mul nzvc", 64'(i32.nzvc), 64'b0110);

    for (int i = 0; i < 400; i++) apply(1, rnd_s(1));
    repeat (40) apply(1, idle_s());

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/rf_alu_datapath_p.md
Name: rf_alu_datapath_p

Overview:
Parametrised successor to the fixed 16-bit register-file-plus-ALU datapath of the multi-cycle RISC core. It generalises data width and register count and adds logic/shift ops. It adds a registered NZVC flag register and an iterative shift-add multiplier with a busy/done handshake. It sits between the control FSM, PC and instruction register, and drives the ALUOut register consumed by write-back and memory address logic.

Parameters:
DATA_W, 16, datapath width; must be >= 16.
NUM_REGS, 8, register-file depth; power of two.
ADDR_W, 3, register address width; equals log2(NUM_REGS).

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
rf_write_en  in  1  register-file write enable
rd_addr  in  ADDR_W  write address
rm_rd_addr  in  ADDR_W  read port A address
rn_addr  in  ADDR_W  read port B address
write_data  in  DATA_W  write data
pc_in  in  DATA_W  PC value for the ALU A mux
instr  in  16  instruction word, immediate source
rd_in  in  DATA_W  Rd value for the imm_sel=11 form
imm_sel  in  2  immediate format
alu_a_sel  in  1  0=pc_in, 1=RF port A
alu_b_sel  in  2  00=RF port B, 01=imm, 10=constant 0, 11=constant 2
alu_op  in  3  operation code
alu_out_ce  in  1  ALUOut/flags load, or MUL start
alu_out  out  DATA_W  registered ALU result
nzvc  out  4  registered flags {N,Z,V,C}
imm_out  out  DATA_W  combinational immediate
read_a_data  out  DATA_W  combinational RF port A
busy  out  1  multiplier running
done  out  1  one-cycle pulse on MUL completion

Behaviour:
Reset (rst_n low, asynchronous):
- All registers, alu_out and nzvc clear to 0.
- busy=0, done=0, multiplier FSM returns to IDLE; any in-flight MUL is aborted.

Register file:
- Write occurs on the rising edge when rf_write_en=1.
- Reads are combinational with no bypass: a same-cycle write/read of one address returns the old value until after the edge.
- R0 is an ordinary writable register.

Immediate generation:
- imm_sel 00: sign-extend instr[4:0].
- 01: sign-extend instr[7:0].
- 10: zero-extend instr[7:0].
- 11: rd_in[7:0] sign-extended to DATA_W (e.g. rd_in=ABAB gives FFAB).

alu_op encoding:
- 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR.
- 101 LSL by B[4:0], 110 LSR by B[4:0]; a shift amount >= DATA_W yields 0.
- 111 MUL.

Single-cycle ops:
- On an edge with alu_out_ce=1 and busy=0, alu_out and nzvc load together; the new value is visible the following cycle.
- When alu_out_ce=0, both registers hold.

Flags:
- N is the result MSB; Z is set when the result is all zero.
- ADD: C = carry out, V = signed overflow.
- SUB: C = borrow (1 when A<B unsigned), V = signed overflow.
- Logic ops: V=0, C=0.
- Shifts: V=0, C = last bit shifted out; C=0 for a shift of 0.

MUL FSM (IDLE, RUN, DONE):
- IDLE to RUN: alu_out_ce=1, alu_op=111, busy=0. Operands A and B are latched and the counter is loaded with DATA_W.
- RUN: one shift-add step per cycle with busy=1. After DATA_W steps, alu_out and nzvc load, and the FSM moves to DONE with busy=0 on that edge.
- MUL result: alu_out = low DATA_W bits of the product. N and Z come from alu_out; V=1 if the high half is nonzero; C=0.
- DONE: done=1 for exactly one cycle, then IDLE. A new MUL start is accepted in the DONE cycle.
- While busy=1, alu_out_ce is ignored, and alu_out and nzvc hold.
- RF writes remain allowed during RUN; the latched operands are unaffected by them.

Test Plan:
- Write Rk=k for k=0..7, then add R3+R5 with alu_out_ce=1 -> alu_out=0008, nzvc=0000 the next cycle.
- SUB R3-R5 -> FFFE, N=1, C=1, V=0. SUB R5-R3 -> 0002, nzvc=0000. ADD 7FFF+0001 -> 8000, V=1, N=1.
- Immediates with R-reg on A:
  - R6 + imm(instr=0007, imm_sel=00) -> 000D.
  - R5 + imm(0018, imm_sel=00) -> FFFD.
  - R3 + imm(0080, imm_sel=01) -> FF83.
  - R2 + imm(00FF, imm_sel=10) -> 0101.
  - R1 + imm(imm_sel=11, rd_in=ABAB) -> FFAC.
- pc_in=1000, alu_a_sel=0, alu_b_sel=11 -> 1002. LSL 0001 by 15 -> 8000, C=0. LSR 0003 by 1 -> 0001, C=1.
- MUL R7*R6:
  - busy is high for exactly 16 cycles, then done pulses once and alu_out=002A.
  - alu_out_ce pulsed mid-RUN has no effect.
  - 0100*0100 -> 0000, Z=1, V=1.
- rst_n dropped mid-MUL -> busy=0, done never pulses, alu_out=0. Repeat with DATA_W=32, NUM_REGS=16: FFFFFFFF+1 -> 0, Z=1, C=1.
